// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline drain buffer: error bit positions
// and the error vector type. Kept free of anything that depends on DEPTH.
package pipe_pkg;

    localparam int ERR_OVF    = 0;
    localparam int ERR_CREDIT = 1;

    typedef logic [1:0] err_t;

endpackage

// File: rtl/drain_fifo_mem.sv
// DEPTH x DATA_WIDTH storage for the drain buffer: one synchronous write
// port and one asynchronous read port. Contents are not reset; validity is
// tracked by the pointers and count in the parent.
module drain_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the accepted pipeline word into its slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_drain_fifo.sv
// Receiving end of a fixed-latency, non-stallable pipeline. Results are
// captured into a circular buffer and offered downstream on valid/ready.
// A credit counter, initialised to DEPTH, lets the upstream issue only when
// a buffer slot is guaranteed for the result.
// Optional feature: define PIPE_DRAIN_FIFO_ERR_EN to add the sticky err port
// (bit ERR_OVF = dropped push, bit ERR_CREDIT = issue with zero credits).
module pipe_drain_fifo
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue,
    output logic                  issue_ok,
    input  logic                  pipe_valid,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready
`ifdef PIPE_DRAIN_FIFO_ERR_EN
    ,
    output err_t                  err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         credits;
    logic [CW-1:0]         credits_next;
    logic                  push;
    logic                  pop;
    logic                  issue_take;
    logic [DATA_WIDTH-1:0] rd_data;

    // A pop frees a slot in the same cycle, so a full buffer can still
    // accept a push when the head is being consumed.
    assign pop        = out_valid & out_ready;
    assign push       = pipe_valid & ((count < DEPTH_C) | pop);
    assign issue_take = issue & (credits != '0);

    // Next occupancy and next credit count.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
        credits_next = credits - CW'(issue_take) + CW'(pop);
    end

    // Pointers, occupancy, credits and the registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            credits   <= DEPTH_C;
            out_valid <= 1'b0;
            issue_ok  <= 1'b1;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count     <= count_next;
            credits   <= credits_next;
            out_valid <= (count_next != '0);
            issue_ok  <= (credits_next != '0);
        end
    end

    drain_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (pipe_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // The head slot is never written while it is valid (a full buffer only
    // writes when the head is popped), so the gated read stays stable while
    // the downstream stalls. Gating gives a defined zero when empty.
    assign out_data = out_valid ? rd_data : '0;

`ifdef PIPE_DRAIN_FIFO_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= '0;
        end else begin
            if (pipe_valid && !push) begin
                err[ERR_OVF] <= 1'b1;
            end
            if (issue && (credits == '0)) begin
                err[ERR_CREDIT] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Self-checking bench for pipe_drain_fifo (DEPTH=4, DATA_WIDTH=32).
// A queue-based reference model predicts outputs after every clock edge.
module tb_pipe_drain_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          issue = 1'b0;
    logic          issue_ok;
    logic          pipe_valid = 1'b0;
    logic [DW-1:0] pipe_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
`ifdef PIPE_DRAIN_FIFO_ERR_EN
    logic [1:0]    err;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [DW-1:0] m_q[$];
    int            m_credits;
    logic [1:0]    m_err;

    // words actually taken from the DUT on pop cycles
    logic [DW-1:0] dut_log[$];

    // 3-stage delay line standing in for the pipeline
    logic          dv[3];
    logic [DW-1:0] dd[3];

    always #5 clk = ~clk;

    pipe_drain_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .issue_ok   (issue_ok),
        .pipe_valid (pipe_valid),
        .pipe_data  (pipe_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
`ifdef PIPE_DRAIN_FIFO_ERR_EN
        ,
        .err        (err)
`endif
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, DW'(out_valid), DW'(m_q.size() != 0));
        check({tag, ".out_data"}, out_data, (m_q.size() != 0) ? m_q[0] : '0);
        check({tag, ".issue_ok"}, DW'(issue_ok), DW'(m_credits != 0));
`ifdef PIPE_DRAIN_FIFO_ERR_EN
        check({tag, ".err"}, DW'(err), DW'(m_err));
`endif
    endtask

    task automatic model_reset();
        m_q.delete();
        m_credits = DEPTH;
        m_err     = 2'b00;
    endtask

    task automatic model_step(input logic iss, input logic pv, input logic [DW-1:0] pd, input logic rdy);
        bit pop_m;
        bit push_m;
        pop_m  = (m_q.size() != 0) && rdy;
        push_m = pv && ((m_q.size() < DEPTH) || pop_m);
        if (pv && !push_m) m_err[0] = 1'b1;
        if (iss && m_credits == 0) m_err[1] = 1'b1;
        if (iss && m_credits != 0) m_credits--;
        if (pop_m) begin
            m_credits++;
            void'(m_q.pop_front());
        end
        if (push_m) m_q.push_back(pd);
    endtask

    task automatic cycle(input string tag, input logic iss, input logic pv, input logic [DW-1:0] pd, input logic rdy);
        issue      = iss;
        pipe_valid = pv;
        pipe_data  = pd;
        out_ready  = rdy;
        if (out_valid && rdy) dut_log.push_back(out_data);
        @(posedge clk);
        model_step(iss, pv, pd, rdy);
        #1;
        check_outputs(tag);
    endtask

    task automatic pipe_cycle(input string tag, input logic iss, input logic rdy, input logic [DW-1:0] word);
        cycle(tag, iss, dv[2], dd[2], rdy);
        dv[2] = dv[1]; dd[2] = dd[1];
        dv[1] = dv[0]; dd[1] = dd[0];
        dv[0] = iss;   dd[0] = word;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        issue = 1'b0; pipe_valid = 1'b0; pipe_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dv[i] = 1'b0;
            dd[i] = '0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs({tag, ".rel"});
    endtask

    initial begin
        int sent;
        int cyc;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            dv[i] = 1'b0;
            dd[i] = '0;
        end

        // 1: credit exhaustion, then an issue with zero credits
        do_reset("t1.rst");
        for (int i = 0; i < 4; i++) cycle("t1.issue", 1'b1, 1'b0, '0, 1'b0);
        cycle("t1.issue5", 1'b1, 1'b0, '0, 1'b0);

        // 2: fill with A..D while stalled, then drain in order
        cycle("t2.push", 1'b0, 1'b1, 32'hA, 1'b0);
        cycle("t2.push", 1'b0, 1'b1, 32'hB, 1'b0);
        cycle("t2.push", 1'b0, 1'b1, 32'hC, 1'b0);
        cycle("t2.push", 1'b0, 1'b1, 32'hD, 1'b0);
        cycle("t2.hold", 1'b0, 1'b0, '0, 1'b0);
        cycle("t2.hold", 1'b0, 1'b0, '0, 1'b0);
        dut_log.delete();
        for (int i = 0; i < 4; i++) cycle("t2.pop", 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) check("t2.order", dut_log[i], DW'(32'hA + i));

        // 3: full buffer, push and pop in the same cycle
        do_reset("t3.rst");
        for (int i = 0; i < 4; i++) cycle("t3.issue", 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("t3.push", 1'b0, 1'b1, DW'(32'hA + i), 1'b0);
        cycle("t3.pushpop", 1'b0, 1'b1, 32'hE, 1'b1);

        // 4: full buffer, push without pop is dropped; order unchanged
        cycle("t4.drop", 1'b0, 1'b1, 32'hF, 1'b0);
        cycle("t4.hold", 1'b0, 1'b0, '0, 1'b0);
        dut_log.delete();
        for (int i = 0; i < 5; i++) cycle("t4.drain", 1'b0, 1'b0, '0, 1'b1);
        check("t4.n", DW'(dut_log.size()), DW'(4));
        check("t4.w0", dut_log[0], 32'hB);
        check("t4.w1", dut_log[1], 32'hC);
        check("t4.w2", dut_log[2], 32'hD);
        check("t4.w3", dut_log[3], 32'hE);

        // 5: streaming issue -> 3-cycle pipeline -> always-ready sink
        do_reset("t5.rst");
        dut_log.delete();
        sent = 0;
        cyc  = 0;
        while (cyc < 200 && dut_log.size() < 20) begin
            logic iss;
            iss = (m_credits > 0) && (sent < 20);
            pipe_cycle("t5.stream", iss, 1'b1, DW'(sent));
            if (iss) sent++;
            cyc++;
        end
        check("t5.count", DW'(dut_log.size()), DW'(20));
        for (int i = 0; i < 20 && i < dut_log.size(); i++) check("t5.order", dut_log[i], DW'(i));

        // 6: reset mid-operation with count=2, credits=1
        do_reset("t6.rst0");
        for (int i = 0; i < 3; i++) cycle("t6.issue", 1'b1, 1'b0, '0, 1'b0);
        cycle("t6.push", 1'b0, 1'b1, 32'h11, 1'b0);
        cycle("t6.push", 1'b0, 1'b1, 32'h22, 1'b0);
        do_reset("t6.rst");

        // random legal traffic through the pipeline model
        for (int i = 0; i < 400; i++) begin
            logic iss;
            logic rdy;
            iss = (m_credits > 0) && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 2) != 0);
            pipe_cycle("rnd", iss, rdy, $urandom);
        end
        for (int i = 0; i < 20; i++) pipe_cycle("rnd.drain", 1'b0, 1'b1, '0);
        check("rnd.empty", DW'(out_valid), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
